// File: rtl/types_pkg.sv
// Shared types for the fetch front end: FSM encoding, NOP filler word and the
// {instruction, pc} record carried through the fetch buffer.
package types_pkg;

  typedef logic [31:0] data_bus;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    data_bus     instr;
    logic [31:0] pc;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry buffer of fetched {instr, pc}; a push is readable one cycle later.
// Flush empties it and cancels same-cycle push/pop; pushing while full is dropped.
module fetch_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry             wdata,
  output fetch_entry             rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The fetch FSM only issues when a slot is reserved, so this never fires.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC + one-outstanding imem read FSM feeding a small instruction buffer.
// Word visible to decode one cycle after rvalid; stops issuing when buffer slots run out.
module instr_fetch_unit
  import types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state    state;
  fetch_state    state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   req_addr;
  logic [31:0]   pending_pc;
  logic          stale;
  logic          stale_nxt;
  logic          outstanding;
  logic          can_issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          empty;
  logic          full;
  fetch_entry    head;
  fetch_entry    wentry;

  assign outstanding = (state != IDLE) && !stale;
  assign can_issue   = !full && ((int'(count) + int'(outstanding)) < DEPTH);
  assign push        = (state == WAIT) && imem_rvalid && !stale && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    stale_nxt    = stale;
    case (state)
      IDLE: begin
        if (!redirect && can_issue) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_nxt = WAIT;
          if (!stale) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          stale_nxt = 1'b0;
          // A same-cycle redirect flushes the buffer, so there is always room.
          state_nxt = (redirect || (count_after < CW'(DEPTH))) ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      // A response consumed this very cycle is already dropped; only mark later ones.
      if ((state == REQ) || ((state == WAIT) && !imem_rvalid)) begin
        stale_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      pending_pc <= '0;
      stale      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      stale    <= stale_nxt;
      if ((state == REQ) && imem_ack) begin
        pending_pc <= fetch_pc;
      end
      // Latch the address on REQ entry so a redirect cannot move a held request.
      if ((state_nxt == REQ) && (state != REQ)) begin
        req_addr <= fetch_pc_nxt;
      end
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = (state == REQ) ? req_addr : fetch_pc;

  assign wentry = '{instr: imem_rdata, pc: pending_pc};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign instr_valid = !empty;
  assign instr       = empty ? NOP_INSTR : head.instr;
  assign instr_pc    = empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory
// (data word = ~address) and a second instance at a wrapping reset PC.
module tb_instr_fetch_unit;
  import types_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // Same inputs, so its handshake timing tracks the main instance exactly.
  instr_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(2)) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (w_valid),
    .instr       (w_instr),
    .instr_pc    (w_pc),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          rv_cnt  = 0;
  int          rv_gap  = 0;
  logic        ack_en  = 1'b1;
  logic [31:0] rv_data = 32'h0;

  initial begin
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = rv_data;
        end
      end
      imem_ack = imem_req && ack_en;
      if (imem_ack) begin
        rv_cnt  = rv_gap + 1;
        rv_data = ~imem_addr;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc);
    chk($sformatf("%s req", tag), 32'(imem_req), 32'(e_req));
    if (e_req) chk($sformatf("%s addr", tag), imem_addr, e_addr);
    chk($sformatf("%s valid", tag), 32'(instr_valid), 32'(e_valid));
    chk($sformatf("%s pc", tag), instr_pc, e_valid ? e_pc : 32'h0);
    chk($sformatf("%s instr", tag), instr, e_valid ? ~e_pc : NOP_INSTR);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    ack_en      = 1'b1;
    rv_gap      = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vec [13];

  initial begin
    //           ready  req   addr    valid  pc
    vec[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vec[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vec[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vec[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vec[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vec[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vec[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vec[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    vec[8]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    vec[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vec[10] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vec[11] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vec[12] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

    // Reset values, fill-to-full, drain and steady-state streaming.
    do_reset();
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset addr", imem_addr, 32'h0);
    chk("reset wrap addr", w_addr, WRAP_PC);
    chk("reset wrap valid", 32'(w_valid), 32'h0);
    for (int i = 0; i < 13; i++) begin
      instr_ready = vec[i].ready;
      tick();
      chk_out($sformatf("row%0d", i), vec[i].req, vec[i].addr, vec[i].valid, vec[i].pc);
      chk($sformatf("row%0d wrap req", i), 32'(w_req), 32'(vec[i].req));
      if (vec[i].req) chk($sformatf("row%0d wrap addr", i), w_addr, vec[i].addr + WRAP_PC);
      chk($sformatf("row%0d wrap valid", i), 32'(w_valid), 32'(vec[i].valid));
      chk($sformatf("row%0d wrap pc", i), w_pc, vec[i].valid ? vec[i].pc + WRAP_PC : 32'h0);
    end

    // Redirect while waiting on a slow response for 0x8.
    do_reset();
    instr_ready = 1'b1;
    rv_gap      = 2;
    repeat (4) tick();
    tick();
    chk_out("rdw e5", 1'b1, 32'h04, 1'b1, 32'h00);
    repeat (3) tick();
    tick();
    chk_out("rdw e9", 1'b1, 32'h08, 1'b1, 32'h04);
    instr_ready = 1'b0;
    tick();
    chk_out("rdw e10", 1'b0, 32'h0, 1'b1, 32'h04);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    chk_out("rdw flush", 1'b0, 32'h0, 1'b0, 32'h0);
    redirect = 1'b0;
    tick();
    chk_out("rdw e12", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rdw stale drop", 1'b1, 32'h100, 1'b0, 32'h0);
    repeat (3) tick();
    tick();
    chk_out("rdw new data", 1'b1, 32'h104, 1'b1, 32'h100);

    // Redirect while the request is held without ack.
    do_reset();
    instr_ready = 1'b1;
    ack_en      = 1'b0;
    tick();
    chk_out("rdq e1", 1'b1, 32'h0, 1'b0, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    tick();
    chk_out("rdq hold1", 1'b1, 32'h0, 1'b0, 32'h0);
    redirect = 1'b0;
    tick();
    chk_out("rdq hold2", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rdq hold3", 1'b1, 32'h0, 1'b0, 32'h0);
    ack_en = 1'b1;
    tick();
    chk_out("rdq wait", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rdq new req", 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    chk_out("rdq e7", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rdq new data", 1'b1, 32'h204, 1'b1, 32'h200);

    // Reset during WAIT, with the old response landing after release.
    do_reset();
    instr_ready = 1'b1;
    rv_gap      = 2;
    tick();
    chk_out("rst e1", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rst e2", 1'b0, 32'h0, 1'b0, 32'h0);
    rst    = 1'b1;
    ack_en = 1'b0;
    #1;
    chk_out("rst async", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst async addr", imem_addr, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_out("rst late rvalid", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rst e6", 1'b1, 32'h0, 1'b0, 32'h0);
    ack_en = 1'b1;
    rv_gap = 0;
    tick();
    chk_out("rst e7", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_out("rst refetch", 1'b1, 32'h04, 1'b1, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
